// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the writeback commit slice:
//   - wbsel_e     : WBsel_WB encodings for the writeback data mux
//   - fpu_cmt_t   : layout of one buffered long-latency FPU completion
//                   {rd, float_dest, data}; the commit FIFO stores entries
//                   packed in this same field order
//   - NOP         : canonical addi x0,x0,0 instruction word
// -----------------------------------------------------------------------------
package fpu_pkg;

    localparam int CMT_XLEN = 32;

    typedef enum logic [1:0] {
        WB_PC  = 2'b00,
        WB_ALU = 2'b01,
        WB_MEM = 2'b10,
        WB_CSR = 2'b11
    } wbsel_e;

    typedef struct packed {
        logic [4:0]          rd;
        logic                float_dest;
        logic [CMT_XLEN-1:0] data;
    } fpu_cmt_t;

    localparam logic [31:0] NOP = 32'h00000013;

endpackage

// File: rtl/wb_cmt_fifo.sv
// -----------------------------------------------------------------------------
// wb_cmt_fifo
// Small synchronous FIFO holding FPU completions until a regfile write port
// is free. The head is presented combinationally so it can commit in the
// same cycle it is popped.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   push, wdata   write request / entry (ignored while full)
//   pop           consume head (ignored while empty)
//   rdata         current head entry
//   full, empty   occupancy flags
//   count         number of valid entries
// -----------------------------------------------------------------------------
module wb_cmt_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == DEPTH_C);
    assign empty  = (count_r == {(AW+1){1'b0}});
    assign count  = count_r;
    assign rdata  = mem_r[rd_ptr_r];
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;

    // Entry storage; written only on an accepted push
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Read/write pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            wr_ptr_r <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_r <= pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        end
    end

    // Occupancy counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/wb_commit_unit_chk.sv
// -----------------------------------------------------------------------------
// wb_commit_unit_chk
// Property checker for the wb_commit_unit FPU interface.
//   - a valid FPU result not yet accepted must stay valid with stable payload
//   - wb_stall may only be raised while a result is buffered
// Ports: observe-only copies of the wb_commit_unit FPU handshake and status.
// -----------------------------------------------------------------------------
module wb_commit_unit_chk #(
    parameter int XLEN = 32
) (
    input logic            clk,
    input logic            rst,
    input logic            fpu_valid,
    input logic            fpu_ready,
    input logic [4:0]      fpu_rd,
    input logic            fpu_float_dest,
    input logic [XLEN-1:0] fpu_data,
    input logic            wb_stall,
    input logic            fpu_pending
);

    property p_fpu_hold;
        @(posedge clk) disable iff (!rst)
            (fpu_valid && !fpu_ready) |=>
                (fpu_valid && $stable({fpu_rd, fpu_float_dest, fpu_data}));
    endproperty

    property p_stall_needs_entry;
        @(posedge clk) disable iff (!rst)
            wb_stall |-> fpu_pending;
    endproperty

    a_fpu_hold:          assert property (p_fpu_hold);
    a_stall_needs_entry: assert property (p_stall_needs_entry);

endmodule

// File: rtl/wb_commit_unit.sv
// -----------------------------------------------------------------------------
// wb_commit_unit
// Writeback-stage commit: selects the MEM/WB writeback value, drives the
// integer/float regfile and CSR write ports, and merges buffered long-latency
// FPU results into the regfile ports. Write outputs are combinational (the
// commit happens in the WB cycle itself); the only state is the completion
// FIFO and the starvation counter.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   *_WB                          MEM/WB pipeline register contents
//   fpu_valid/ready/rd/float_dest/data   FPU completion handshake
//   int_we/waddr/wdata            integer regfile write port
//   fp_we/waddr/wdata             float regfile write port
//   csr_we/waddr/wdata            CSR file write port
//   wb_stall                      hold IF..MEM/WB for one cycle
//   fpu_pending                   completion FIFO non-empty
// -----------------------------------------------------------------------------
module wb_commit_unit
    import fpu_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_next_WB,
    input  logic [XLEN-1:0] ALUout_WB,
    input  logic [XLEN-1:0] d_mem_out_WB,
    input  logic [XLEN-1:0] csr_data_r_WB,
    input  logic [XLEN-1:0] csr_data_out_WB,
    input  logic [11:0]     csr_address_WB,
    input  logic [31:0]     inst_WB,
    input  logic [1:0]      WBsel_WB,
    input  logic            csrWBsel_WB,
    input  logic            regW_en_WB,
    input  logic            rsW_float_WB,
    input  logic            csrW_en_WB,
    input  logic            fpu_valid,
    output logic            fpu_ready,
    input  logic [4:0]      fpu_rd,
    input  logic            fpu_float_dest,
    input  logic [XLEN-1:0] fpu_data,
    output logic            int_we,
    output logic [4:0]      int_waddr,
    output logic [XLEN-1:0] int_wdata,
    output logic            fp_we,
    output logic [4:0]      fp_waddr,
    output logic [XLEN-1:0] fp_wdata,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            wb_stall,
    output logic            fpu_pending
);

    localparam int ENTRY_W = 5 + 1 + XLEN;
    localparam int SW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    logic [4:0]              rd_s;
    logic [XLEN-1:0]         sel_data_s;
    logic [XLEN-1:0]         pipe_data_s;
    logic                    pipe_we_s;
    logic                    pipe_commit_s;
    logic [ENTRY_W-1:0]      push_entry_s;
    logic [ENTRY_W-1:0]      head_entry_s;
    logic [4:0]              head_rd_s;
    logic                    head_float_s;
    logic [XLEN-1:0]         head_data_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
    logic                    head_valid_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    conflict_s;
    logic                    wb_stall_s;
    logic [SW-1:0]           starve_cnt_r;
    logic                    unused_inst_s;

    assign rd_s          = inst_WB[11:7];
    assign unused_inst_s = ^{inst_WB[31:12], inst_WB[6:0]};

    // Writeback data mux
    always_comb begin
        sel_data_s = '0;
        case (WBsel_WB)
            WB_PC:   sel_data_s = pc_next_WB;
            WB_ALU:  sel_data_s = ALUout_WB;
            WB_MEM:  sel_data_s = d_mem_out_WB;
            WB_CSR:  sel_data_s = csr_data_r_WB;
            default: sel_data_s = '0;
        endcase
    end

    assign pipe_data_s = csrWBsel_WB ? csr_data_r_WB : sel_data_s;
    // x0 is hardwired in the integer file only; f0 is a real register
    assign pipe_we_s   = regW_en_WB & ~(~rsW_float_WB & (rd_s == 5'd0));

    // Integer-destination results for x0 are dropped at the door
    assign push_s       = fpu_valid & ~fifo_full_s & (fpu_float_dest | (fpu_rd != 5'd0));
    assign push_entry_s = {fpu_rd, fpu_float_dest, fpu_data};
    assign fpu_ready    = ~fifo_full_s;

    wb_cmt_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (push_entry_s),
        .rdata (head_entry_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign head_rd_s    = head_entry_s[ENTRY_W-1 -: 5];
    assign head_float_s = head_entry_s[XLEN];
    assign head_data_s  = head_entry_s[XLEN-1:0];
    assign head_valid_s = ~fifo_empty_s;
    assign fpu_pending  = (fifo_count_s != '0);

    // The head only contends when the pipeline wants the same port
    assign conflict_s    = pipe_we_s & (rsW_float_WB == head_float_s);
    assign wb_stall_s    = head_valid_s & (starve_cnt_r == STARVE_MAX);
    // During a stall the head takes its port; MEM/WB holds, so the pipeline
    // write is simply deferred to the next cycle
    assign pop_s         = head_valid_s & (wb_stall_s | ~conflict_s);
    assign pipe_commit_s = pipe_we_s & ~wb_stall_s;
    assign wb_stall      = wb_stall_s;

    // Regfile port steering; pipeline and head never target the same port
    always_comb begin
        int_we    = 1'b0;
        int_waddr = '0;
        int_wdata = '0;
        fp_we     = 1'b0;
        fp_waddr  = '0;
        fp_wdata  = '0;
        if (rst) begin
            if (pipe_commit_s && !rsW_float_WB) begin
                int_we    = 1'b1;
                int_waddr = rd_s;
                int_wdata = pipe_data_s;
            end else if (pop_s && !head_float_s) begin
                int_we    = 1'b1;
                int_waddr = head_rd_s;
                int_wdata = head_data_s;
            end else begin
                int_we    = 1'b0;
            end
            if (pipe_commit_s && rsW_float_WB) begin
                fp_we     = 1'b1;
                fp_waddr  = rd_s;
                fp_wdata  = pipe_data_s;
            end else if (pop_s && head_float_s) begin
                fp_we     = 1'b1;
                fp_waddr  = head_rd_s;
                fp_wdata  = head_data_s;
            end else begin
                fp_we     = 1'b0;
            end
        end else begin
            int_we = 1'b0;
            fp_we  = 1'b0;
        end
    end

    assign csr_we    = rst & csrW_en_WB & ~wb_stall_s;
    assign csr_waddr = csr_address_WB;
    assign csr_wdata = csr_data_out_WB;

    // Starvation counter: counts lost arbitrations of the current head,
    // saturates at the limit and clears whenever an entry drains
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= '0;
        end else if (pop_s) begin
            starve_cnt_r <= '0;
        end else if (head_valid_s && conflict_s && (starve_cnt_r != STARVE_MAX)) begin
            starve_cnt_r <= starve_cnt_r + STARVE_ONE;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: tb/tb_wb_commit_unit.sv
// -----------------------------------------------------------------------------
// tb_wb_commit_unit
// Self-checking bench for wb_commit_unit. Expected regfile/CSR writes are
// queued per port as stimulus is driven; a negedge monitor pops and compares
// every write the DUT commits. Status outputs are compared directly.
// -----------------------------------------------------------------------------
module tb_wb_commit_unit;
    import fpu_pkg::*;

    localparam logic [31:0] PC_C   = 32'h0000_0100;
    localparam logic [31:0] MEM_C  = 32'hDEAD_0000;
    localparam logic [31:0] CSRR_C = 32'h0000_1800;

    logic        clk, rst;
    logic [31:0] pc_next_WB, ALUout_WB, d_mem_out_WB, csr_data_r_WB, csr_data_out_WB;
    logic [11:0] csr_address_WB;
    logic [31:0] inst_WB;
    logic [1:0]  WBsel_WB;
    logic        csrWBsel_WB, regW_en_WB, rsW_float_WB, csrW_en_WB;
    logic        fpu_valid, fpu_ready, fpu_float_dest;
    logic [4:0]  fpu_rd;
    logic [31:0] fpu_data;
    logic        int_we, fp_we, csr_we;
    logic [4:0]  int_waddr, fp_waddr;
    logic [31:0] int_wdata, fp_wdata, csr_wdata;
    logic [11:0] csr_waddr;
    logic        wb_stall, fpu_pending;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t int_q[$];
    wr_t fp_q[$];
    wr_t csr_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    wb_commit_unit #(.XLEN(32), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .pc_next_WB(pc_next_WB), .ALUout_WB(ALUout_WB), .d_mem_out_WB(d_mem_out_WB),
        .csr_data_r_WB(csr_data_r_WB), .csr_data_out_WB(csr_data_out_WB),
        .csr_address_WB(csr_address_WB), .inst_WB(inst_WB), .WBsel_WB(WBsel_WB),
        .csrWBsel_WB(csrWBsel_WB), .regW_en_WB(regW_en_WB), .rsW_float_WB(rsW_float_WB),
        .csrW_en_WB(csrW_en_WB), .fpu_valid(fpu_valid), .fpu_ready(fpu_ready),
        .fpu_rd(fpu_rd), .fpu_float_dest(fpu_float_dest), .fpu_data(fpu_data),
        .int_we(int_we), .int_waddr(int_waddr), .int_wdata(int_wdata),
        .fp_we(fp_we), .fp_waddr(fp_waddr), .fp_wdata(fp_wdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .wb_stall(wb_stall), .fpu_pending(fpu_pending)
    );

    wb_commit_unit_chk #(.XLEN(32)) u_chk (
        .clk(clk), .rst(rst), .fpu_valid(fpu_valid), .fpu_ready(fpu_ready),
        .fpu_rd(fpu_rd), .fpu_float_dest(fpu_float_dest), .fpu_data(fpu_data),
        .wb_stall(wb_stall), .fpu_pending(fpu_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
        n_checks++;
        if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs_v, exp_v);
        end
    endtask

    // Scoreboard monitor: each committed write must match the oldest expectation
    always @(negedge clk) begin : mon
        wr_t e;
        if (rst) begin
            if (int_we) begin
                if (int_q.size() == 0) check_eq("int_spurious", 64'(int_we), 64'd0);
                else begin
                    e = int_q.pop_front();
                    check_eq("int_waddr", 64'(int_waddr), 64'(e.addr));
                    check_eq("int_wdata", 64'(int_wdata), 64'(e.data));
                end
            end
            if (fp_we) begin
                if (fp_q.size() == 0) check_eq("fp_spurious", 64'(fp_we), 64'd0);
                else begin
                    e = fp_q.pop_front();
                    check_eq("fp_waddr", 64'(fp_waddr), 64'(e.addr));
                    check_eq("fp_wdata", 64'(fp_wdata), 64'(e.data));
                end
            end
            if (csr_we) begin
                if (csr_q.size() == 0) check_eq("csr_spurious", 64'(csr_we), 64'd0);
                else begin
                    e = csr_q.pop_front();
                    check_eq("csr_waddr", 64'(csr_waddr), 64'(e.addr));
                    check_eq("csr_wdata", 64'(csr_wdata), 64'(e.data));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic set_idle();
        pc_next_WB = PC_C;  ALUout_WB = 32'h0;  d_mem_out_WB = MEM_C;
        csr_data_r_WB = CSRR_C;  csr_data_out_WB = 32'h0;  csr_address_WB = 12'h000;
        inst_WB = NOP;  WBsel_WB = WB_ALU;  csrWBsel_WB = 1'b0;
        regW_en_WB = 1'b0;  rsW_float_WB = 1'b0;  csrW_en_WB = 1'b0;
        fpu_valid = 1'b0;  fpu_rd = 5'd0;  fpu_float_dest = 1'b0;  fpu_data = 32'h0;
    endtask

    task automatic set_pipe(input logic en, input logic flt, input logic [4:0] rd,
                            input logic [1:0] sel, input logic [31:0] val);
        logic [31:0] ins;
        set_idle();
        ins = NOP;
        ins[11:7] = rd;
        inst_WB = ins;
        regW_en_WB = en;
        rsW_float_WB = flt;
        WBsel_WB = sel;
        ALUout_WB = val;
    endtask

    task automatic push_exp(input logic flt, input logic [4:0] rd, input logic [31:0] data);
        if (flt) fp_q.push_back('{addr: {7'd0, rd}, data: data});
        else     int_q.push_back('{addr: {7'd0, rd}, data: data});
    endtask

    function automatic logic [31:0] exp_data(input logic [1:0] sel, input logic [31:0] val);
        case (sel)
            2'b00:   return PC_C;
            2'b01:   return val;
            2'b10:   return MEM_C;
            default: return CSRR_C;
        endcase
    endfunction

    // One plain pipeline write with no FPU traffic
    task automatic pipe_cycle(input logic en, input logic flt, input logic [4:0] rd,
                              input logic [1:0] sel, input logic [31:0] val);
        logic wr;
        set_pipe(en, flt, rd, sel, val);
        wr = en & (flt | (rd != 5'd0));
        if (wr) push_exp(flt, rd, exp_data(sel, val));
        mid();
        check_eq("pipe_int_we", 64'(int_we), 64'(wr & ~flt));
        check_eq("pipe_fp_we",  64'(fp_we),  64'(wr & flt));
        cyc();
    endtask

    task automatic check_drained(input string tag);
        check_eq({tag, "_intq"}, 64'(int_q.size()), 64'd0);
        check_eq({tag, "_fpq"},  64'(fp_q.size()),  64'd0);
        check_eq({tag, "_csrq"}, 64'(csr_q.size()), 64'd0);
    endtask

    initial begin
        int          idx;
        logic        stall_seen;
        logic [6:0]  rdy_exp;

        set_idle();
        rst = 1'b0;
        #2;
        check_eq("rst_int_we", 64'(int_we), 64'd0);
        check_eq("rst_fp_we", 64'(fp_we), 64'd0);
        check_eq("rst_csr_we", 64'(csr_we), 64'd0);
        check_eq("rst_stall", 64'(wb_stall), 64'd0);
        check_eq("rst_pending", 64'(fpu_pending), 64'd0);
        check_eq("rst_ready", 64'(fpu_ready), 64'd1);
        cyc();
        rst = 1'b1;

        // Writeback mux and x0 / f0 handling
        pipe_cycle(1'b1, 1'b0, 5'd5, WB_ALU, 32'h1234);
        pipe_cycle(1'b1, 1'b0, 5'd6, WB_PC,  32'h0);
        pipe_cycle(1'b1, 1'b0, 5'd7, WB_MEM, 32'h0);
        pipe_cycle(1'b1, 1'b0, 5'd8, WB_CSR, 32'h0);
        pipe_cycle(1'b1, 1'b0, 5'd0, WB_ALU, 32'h5555);
        pipe_cycle(1'b1, 1'b1, 5'd0, WB_ALU, 32'h55);
        pipe_cycle(1'b0, 1'b0, 5'd9, WB_ALU, 32'h99);

        // FPU float result drains alongside an integer pipeline write
        set_pipe(1'b1, 1'b0, 5'd7, WB_ALU, 32'h77);
        fpu_valid = 1'b1; fpu_rd = 5'd3; fpu_float_dest = 1'b1; fpu_data = 32'h40490FDB;
        push_exp(1'b0, 5'd7, 32'h77);
        mid();
        check_eq("t2_ready", 64'(fpu_ready), 64'd1);
        check_eq("t2_pend_before", 64'(fpu_pending), 64'd0);
        cyc();
        set_pipe(1'b1, 1'b0, 5'd8, WB_ALU, 32'h88);
        push_exp(1'b0, 5'd8, 32'h88);
        push_exp(1'b1, 5'd3, 32'h40490FDB);
        mid();
        check_eq("t2_fp_we", 64'(fp_we), 64'd1);
        check_eq("t2_int_we", 64'(int_we), 64'd1);
        check_eq("t2_pend", 64'(fpu_pending), 64'd1);
        cyc();
        set_idle();
        mid();
        check_eq("t2_pend_after", 64'(fpu_pending), 64'd0);
        check_drained("t2");
        cyc();

        // Integer-destination FPU result for x0 is accepted and discarded
        fpu_valid = 1'b1; fpu_rd = 5'd0; fpu_float_dest = 1'b0; fpu_data = 32'hFFFF;
        mid();
        check_eq("x0_ready", 64'(fpu_ready), 64'd1);
        cyc();
        set_idle();
        mid();
        check_eq("x0_discard", 64'(fpu_pending), 64'd0);
        cyc();

        // Starvation: pipeline wins 4 cycles, then one stall cycle drains FPU
        for (int i = 0; i < 5; i++) push_exp(1'b1, 5'(1 + i), 32'(32'hF000 + i));
        push_exp(1'b1, 5'd9, 32'hCAFEF00D);
        push_exp(1'b1, 5'd6, 32'hF005);
        for (int i = 0; i < 6; i++) csr_q.push_back('{addr: 12'h340, data: 32'(i)});
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            set_pipe(1'b1, 1'b1, 5'(1 + idx), WB_ALU, 32'(32'hF000 + idx));
            csrW_en_WB = 1'b1; csr_address_WB = 12'h340; csr_data_out_WB = 32'(idx);
            fpu_valid = (c == 0); fpu_rd = 5'd9; fpu_float_dest = 1'b1; fpu_data = 32'hCAFEF00D;
            mid();
            check_eq("t3_stall", 64'(wb_stall), 64'(c == 5));
            stall_seen = wb_stall;
            cyc();
            if (!stall_seen) idx++;
        end
        set_idle();
        mid();
        check_eq("t3_pend_after", 64'(fpu_pending), 64'd0);
        check_drained("t3");
        cyc();

        // Back-to-back pushes while the float port is busy; third is held
        rdy_exp = 7'b1100011;
        for (int c = 0; c < 4; c++) push_exp(1'b1, 5'(1 + c), 32'(32'hE000 + c));
        push_exp(1'b1, 5'd11, 32'hA1);
        push_exp(1'b1, 5'd12, 32'hB2);
        push_exp(1'b1, 5'd13, 32'hC3);
        for (int c = 4; c < 7; c++) push_exp(1'b0, 5'(16 + c), 32'(32'h2000 + c));
        for (int c = 0; c < 7; c++) begin
            if (c < 4) set_pipe(1'b1, 1'b1, 5'(1 + c), WB_ALU, 32'(32'hE000 + c));
            else       set_pipe(1'b1, 1'b0, 5'(16 + c), WB_ALU, 32'(32'h2000 + c));
            fpu_valid = (c < 6); fpu_float_dest = 1'b1;
            case (c)
                0:       begin fpu_rd = 5'd11; fpu_data = 32'hA1; end
                1:       begin fpu_rd = 5'd12; fpu_data = 32'hB2; end
                default: begin fpu_rd = 5'd13; fpu_data = 32'hC3; end
            endcase
            mid();
            check_eq("t4_ready", 64'(fpu_ready), 64'(rdy_exp[c]));
            check_eq("t4_stall", 64'(wb_stall), 64'd0);
            cyc();
        end
        set_idle();
        mid();
        check_eq("t4_pend_after", 64'(fpu_pending), 64'd0);
        check_drained("t4");
        cyc();

        // CSR write with csrWBsel routing the CSR read value into x10
        set_pipe(1'b1, 1'b0, 5'd10, WB_ALU, 32'hBAD);
        csrWBsel_WB = 1'b1; csrW_en_WB = 1'b1;
        csr_address_WB = 12'h300; csr_data_out_WB = 32'h8;
        push_exp(1'b0, 5'd10, CSRR_C);
        csr_q.push_back('{addr: 12'h300, data: 32'h8});
        mid();
        check_eq("t5_csr_we", 64'(csr_we), 64'd1);
        cyc();
        set_idle();
        mid();
        check_drained("t5");
        cyc();

        // Async reset mid-cycle with two buffered entries
        set_pipe(1'b1, 1'b1, 5'd1, WB_ALU, 32'hD000);
        fpu_valid = 1'b1; fpu_rd = 5'd14; fpu_float_dest = 1'b1; fpu_data = 32'hAAAA;
        push_exp(1'b1, 5'd1, 32'hD000);
        mid();
        cyc();
        set_pipe(1'b1, 1'b1, 5'd2, WB_ALU, 32'hD001);
        fpu_valid = 1'b1; fpu_rd = 5'd15; fpu_float_dest = 1'b1; fpu_data = 32'hBBBB;
        push_exp(1'b1, 5'd2, 32'hD001);
        mid();
        check_eq("t6_pend", 64'(fpu_pending), 64'd1);
        cyc();
        set_pipe(1'b1, 1'b1, 5'd3, WB_ALU, 32'hD002);
        csrW_en_WB = 1'b1; csr_address_WB = 12'h341; csr_data_out_WB = 32'h5;
        push_exp(1'b1, 5'd3, 32'hD002);
        csr_q.push_back('{addr: 12'h341, data: 32'h5});
        mid();
        check_eq("t6_full", 64'(fpu_ready), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("t6_int_we", 64'(int_we), 64'd0);
        check_eq("t6_fp_we", 64'(fp_we), 64'd0);
        check_eq("t6_csr_we", 64'(csr_we), 64'd0);
        check_eq("t6_stall", 64'(wb_stall), 64'd0);
        check_eq("t6_pend_rst", 64'(fpu_pending), 64'd0);
        check_eq("t6_ready_rst", 64'(fpu_ready), 64'd1);
        cyc();
        set_idle();
        rst = 1'b1;
        mid();
        check_eq("t6_pend_after", 64'(fpu_pending), 64'd0);
        check_eq("t6_fp_we_after", 64'(fp_we), 64'd0);
        check_drained("t6");
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Writeback-side consumer of the MEM/WB pipeline register. Selects the writeback data and drives the integer regfile, float regfile and CSR write ports.
- Also merges results from the long-latency FPU (fdiv/fsqrt) into those regfile write ports through a small completion FIFO.
- Arbitrates write-port conflicts. Asserts a one-cycle pipeline stall when a buffered FPU result starves.
- Sits after MEM/WB, in parallel with the regfiles and CSR file.

Parameters:
- XLEN, 32, datapath width
- FIFO_DEPTH, 2, FPU completion buffer entries (power of 2, >=2)
- STARVE_LIMIT, 4, cycles a FIFO head may lose arbitration before wb_stall is forced

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- pc_next_WB  in  XLEN  link value
- ALUout_WB  in  XLEN  ALU/FPU-short result
- d_mem_out_WB  in  XLEN  load data
- csr_data_r_WB  in  XLEN  CSR read value
- csr_data_out_WB  in  XLEN  CSR write value
- csr_address_WB  in  12  CSR address
- inst_WB  in  32  instruction (rd = [11:7])
- WBsel_WB  in  2  00 pc_next, 01 ALUout, 10 d_mem_out, 11 csr_data_r
- csrWBsel_WB  in  1  1: reg data = csr_data_r_WB regardless of WBsel
- regW_en_WB  in  1  pipeline register write request
- rsW_float_WB  in  1  1: destination is float regfile
- csrW_en_WB  in  1  CSR write request
- fpu_valid  in  1  long-latency FPU result valid
- fpu_ready  out  1  FIFO can accept (not full)
- fpu_rd  in  5  FPU destination
- fpu_float_dest  in  1  1: float regfile, 0: int (fcvt/fclass/compare)
- fpu_data  in  XLEN  FPU result
- int_we / int_waddr / int_wdata  out  1/5/XLEN  integer regfile write
- fp_we / fp_waddr / fp_wdata  out  1/5/XLEN  float regfile write
- csr_we / csr_waddr / csr_wdata  out  1/12/XLEN  CSR write
- wb_stall  out  1  hold IF..MEM/WB (drives MEM_WB en low)
- fpu_pending  out  1  FIFO non-empty

Behaviour:
- Reset (rst=0, async):
  - FIFO empty, pointers and count 0, starve counter 0.
  - All we outputs 0, wb_stall 0, fpu_pending 0, fpu_ready 1.
- Write outputs are combinational from the WB inputs and the FIFO head: zero-latency commit. State is the FIFO plus the starve counter only.
- Pipeline write request:
  - pipe_we = regW_en_WB & !(~rsW_float_WB & rd==0).
  - Data = csr_data_r_WB if csrWBsel_WB, else the WBsel mux.
  - Targets the float port if rsW_float_WB, else the int port.
- CSR port: csr_we = csrW_en_WB & !wb_stall, with address and data passed through. Never contended.
- FIFO:
  - Push when fpu_valid & fpu_ready. The entry is {rd, float_dest, data}.
  - An int-destination entry with rd==0 is accepted and discarded: no push.
  - fpu_ready = !full. A push while full is ignored; an FPU that violates the handshake is an assertion failure.
  - Simultaneous push and pop when full: not allowed, because ready is 0 while full (no bypass).
- Head arbitration, each cycle the FIFO is non-empty:
  - If wb_stall=1, the head wins its port and the pipeline write is suppressed. MEM/WB holds, so the instruction commits next cycle.
  - Else, if the pipeline targets the other port or pipe_we=0, the head drains on its port in the same cycle.
  - Else, the pipeline wins and the starve counter increments.
- Pop on head drain; the starve counter clears to 0 on every pop.
- wb_stall = (starve_cnt == STARVE_LIMIT) & non-empty. It is high for exactly one cycle per starvation event, then the counter clears.
- Same-rd hazard: ordering between the pipeline and the FPU to the same rd is the scoreboard's job (outside this block). This block does not reorder.
- Counter saturates at STARVE_LIMIT; no wrap.
- Reset mid-operation discards buffered results. The issue-side scoreboard must also be reset.

Decomposition:
- Shared package fpu_pkg:
  - WBsel encodings (WB_PC, WB_ALU, WB_MEM, WB_CSR).
  - fpu_cmt_t struct {rd, float_dest, data}.
  - NOP constant 32'h00000013.
- Sub-module: wb_cmt_fifo, a parameterized sync FIFO with count, full and empty.

Test Plan:
- Reset, then ALUout_WB=0x1234, WBsel=01, regW_en=1, rd=5, int -> int_we=1, waddr=5, wdata=0x1234. rd=0 -> int_we=0.
- FPU push rd=3, float_dest=1, data=0x40490FDB while the pipeline writes int x7 -> fp_we=1, fp_waddr=3 and int_we=1 in the same cycle; FIFO empties.
- FPU float result with a continuous pipeline float write every cycle -> pipeline wins 4 cycles, 5th cycle wb_stall=1, fp port carries the FPU data, pipeline write suppressed. Next cycle the held pipeline write commits and wb_stall=0.
- Push 2 results back-to-back while the float port is blocked -> fpu_ready=0 after the 2nd. A 3rd fpu_valid is not accepted and the bench holds it; drains occur in order.
- csrW_en=1, addr=0x300, csr_data_out=0x8 with csrWBsel=1, csr_data_r=0x1800, rd=10 -> csr_we=1 to 0x300 with 0x8, and int x10 written with 0x1800.
- Async reset asserted with 2 FIFO entries mid-clock -> outputs zero immediately, fpu_pending=0, fpu_ready=1.
